// File: rtl/core_pkg.sv
// Shared core definitions: controller state codes, the nop encoding and the
// instruction-fetch handshake FSM states.
package core_pkg;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WRITE  = 3'd4;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int IMEM_AW_DEFAULT = 15;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_REQ,
        FS_WAIT,
        FS_DONE
    } fetch_st_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response handshake between the fetch stage
// (master) and instruction memory (slave).
interface fetch_unit_if import core_pkg::*; #(
    parameter int AW = IMEM_AW_DEFAULT
);

    logic          req;
    logic [AW-1:0] addr;
    logic          ready;
    logic          rvalid;
    logic [31:0]   rdata;

    modport master (output req, output addr, input ready, input rvalid, input rdata);
    modport slave  (input req, input addr, output ready, output rvalid, output rdata);

endinterface

// File: rtl/fetch_unit_pc_reg.sv
// Program counter with next-PC select, sticky misaligned-redirect flag and
// the retired-instruction counter; all advance only on a qualified commit.
module pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_commit,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    output logic [31:0] o_pc,
    output logic [31:0] o_instret,
    output logic        o_misalign
);

    logic [31:0] r_pc;
    logic [31:0] r_instret;
    logic        r_misalign;
    logic [31:0] w_next_pc;
    logic        w_target_misaligned;

    // Redirect targets are forced to word alignment; the low bits only feed the flag.
    always_comb begin
        w_target_misaligned = i_branch_taken && (i_branch_target[1:0] != 2'b00);
        w_next_pc = i_branch_taken ? {i_branch_target[31:2], 2'b00} : r_pc + 32'd4;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_instret  <= 32'd0;
            r_misalign <= 1'b0;
        end else if (i_commit) begin
            r_pc      <= w_next_pc;
            r_instret <= r_instret + 32'd1;
            if (w_target_misaligned) begin
                r_misalign <= 1'b1;
            end
        end
    end

    assign o_pc       = r_pc;
    assign o_instret  = r_instret;
    assign o_misalign = r_misalign;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one memory request per FETCH visit, latches the
// returned word for the decoder and owns the PC via pc_reg.
module fetch_unit import core_pkg::*; #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = IMEM_AW_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [2:0]   i_state,
    fetch_unit_if.master imem,
    input  logic         i_commit,
    input  logic         i_branch_taken,
    input  logic [31:0]  i_branch_target,
    output logic [31:0]  o_pc,
    output logic [31:0]  o_instr_raw,
    output logic         o_fetch_done,
    output logic         o_misalign,
    output logic [31:0]  o_instret
);

    fetch_st_t   r_fsm;
    logic        r_req;
    logic        r_fetch_done;
    logic        r_drop;
    logic [31:0] r_instr;
    logic        w_in_fetch;
    logic        w_commit;
    logic [31:0] w_pc;

    assign w_in_fetch = (i_state == ST_FETCH);

    // A commit outside IDLE, or colliding with a response, is a protocol error and is dropped.
    assign w_commit = i_commit && (r_fsm == FS_IDLE) && !imem.rvalid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm        <= FS_IDLE;
            r_req        <= 1'b0;
            r_fetch_done <= 1'b0;
            r_drop       <= 1'b0;
            r_instr      <= NOP_INSTR;
        end else begin
            r_fetch_done <= 1'b0;
            case (r_fsm)
                FS_IDLE: begin
                    if (w_in_fetch) begin
                        r_fsm <= FS_REQ;
                        r_req <= 1'b1;
                    end
                end
                FS_REQ: begin
                    // Once accepted a response is owed, so it must be consumed even if FETCH ended.
                    if (imem.ready) begin
                        r_fsm  <= FS_WAIT;
                        r_req  <= 1'b0;
                        r_drop <= !w_in_fetch;
                    end else if (!w_in_fetch) begin
                        r_fsm <= FS_IDLE;
                        r_req <= 1'b0;
                    end
                end
                FS_WAIT: begin
                    if (imem.rvalid) begin
                        r_drop <= 1'b0;
                        if (r_drop || !w_in_fetch) begin
                            r_fsm <= FS_IDLE;
                        end else begin
                            r_instr      <= imem.rdata;
                            r_fetch_done <= 1'b1;
                            r_fsm        <= FS_DONE;
                        end
                    end else if (!w_in_fetch) begin
                        r_drop <= 1'b1;
                    end
                end
                FS_DONE: begin
                    r_fsm <= FS_IDLE;
                end
                default: begin
                    r_fsm <= FS_IDLE;
                end
            endcase
        end
    end

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk             (clk),
        .rst             (rst),
        .i_commit        (w_commit),
        .i_branch_taken  (i_branch_taken),
        .i_branch_target (i_branch_target),
        .o_pc            (w_pc),
        .o_instret       (o_instret),
        .o_misalign      (o_misalign)
    );

    assign imem.req     = r_req;
    assign imem.addr    = w_pc[IMEM_AW+1:2];
    assign o_pc         = w_pc;
    assign o_instr_raw  = r_instr;
    assign o_fetch_done = r_fetch_done;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit, checked against a
// behavioural model of PC, instret, misalign and the latched instruction.
module tb_fetch_unit;
    import core_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  state;
    logic        commit;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic [31:0] pc;
    logic [31:0] instrRaw;
    logic        fetchDone;
    logic        misalign;
    logic [31:0] instret;

    int total = 0;
    int bad   = 0;

    logic [31:0] mPc;
    logic [31:0] mInstret;
    logic        mMisalign;
    logic [31:0] mInstr;

    fetch_unit_if #(.AW(15)) imem ();

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .IMEM_AW  (15)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_state         (state),
        .imem            (imem),
        .i_commit        (commit),
        .i_branch_taken  (branchTaken),
        .i_branch_target (branchTarget),
        .o_pc            (pc),
        .o_instr_raw     (instrRaw),
        .o_fetch_done    (fetchDone),
        .o_misalign      (misalign),
        .o_instret       (instret)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive every input, then advance one clock and settle just past the edge.
    task automatic applyStimulus(input logic [2:0] st, input logic rdy, input logic rv,
                                 input logic [31:0] rd, input logic cm, input logic tk,
                                 input logic [31:0] tgt);
        state        = st;
        imem.ready   = rdy;
        imem.rvalid  = rv;
        imem.rdata   = rd;
        commit       = cm;
        branchTaken  = tk;
        branchTarget = tgt;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] expAddr(input logic [31:0] p);
        return (p / 4) % 32768;
    endfunction

    task automatic checkArch(input string tag);
        checkOutput({tag, "_pc"}, pc, mPc);
        checkOutput({tag, "_instret"}, instret, mInstret);
        checkOutput({tag, "_misalign"}, {31'd0, misalign}, {31'd0, mMisalign});
    endtask

    task automatic doFetch(input logic [31:0] word, input int readyDelay, input int rspDelay);
        applyStimulus(ST_FETCH, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        checkOutput("req_raise", {31'd0, imem.req}, 32'd1);
        checkOutput("addr", {17'd0, imem.addr}, expAddr(mPc));
        for (int i = 0; i < readyDelay; i++) begin
            applyStimulus(ST_FETCH, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
            checkOutput("req_stall", {31'd0, imem.req}, 32'd1);
            checkOutput("addr_stall", {17'd0, imem.addr}, expAddr(mPc));
        end
        applyStimulus(ST_FETCH, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        checkOutput("req_after_accept", {31'd0, imem.req}, 32'd0);
        checkOutput("done_early", {31'd0, fetchDone}, 32'd0);
        for (int i = 0; i < rspDelay; i++) begin
            applyStimulus(ST_FETCH, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
            checkOutput("done_wait", {31'd0, fetchDone}, 32'd0);
        end
        applyStimulus(ST_FETCH, 1'b0, 1'b1, word, 1'b0, 1'b0, 32'd0);
        mInstr = word;
        checkOutput("fetch_done", {31'd0, fetchDone}, 32'd1);
        checkOutput("instr_raw", instrRaw, mInstr);
        checkOutput("pc_during_fetch", pc, mPc);
        applyStimulus(ST_DECODE, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        checkOutput("done_pulse", {31'd0, fetchDone}, 32'd0);
        checkOutput("instr_hold", instrRaw, mInstr);
    endtask

    task automatic doCommit(input logic tk, input logic [31:0] tgt);
        applyStimulus(ST_WRITE, 1'b0, 1'b0, 32'd0, 1'b1, tk, tgt);
        if (tk) begin
            mPc = tgt & 32'hFFFF_FFFC;
            if (tgt % 4 != 0) mMisalign = 1'b1;
        end else begin
            mPc = mPc + 32'd4;
        end
        mInstret = mInstret + 32'd1;
        checkArch("commit");
        checkOutput("instr_commit", instrRaw, mInstr);
    endtask

    task automatic modelReset();
        mPc       = RESET_PC;
        mInstret  = 32'd0;
        mMisalign = 1'b0;
        mInstr    = NOP_INSTR;
    endtask

    initial begin
        logic [31:0] word;
        logic [31:0] tgt;
        logic        tk;

        rst = 1'b1;
        modelReset();
        applyStimulus(ST_DECODE, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        applyStimulus(ST_DECODE, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        rst = 1'b0;
        checkArch("reset");
        checkOutput("reset_req", {31'd0, imem.req}, 32'd0);
        checkOutput("reset_done", {31'd0, fetchDone}, 32'd0);
        checkOutput("reset_instr", instrRaw, 32'h0000_0013);

        $display("[TB] first fetch at minimum latency");
        doFetch(32'h0050_0093, 0, 0);

        $display("[TB] sequential and wrapping PC updates");
        doCommit(1'b1, 32'h0000_0010);
        doCommit(1'b0, 32'd0);
        checkOutput("pc_0x14", pc, 32'h0000_0014);
        doCommit(1'b1, 32'hFFFF_FFFC);
        doFetch($urandom, 0, 1);
        doCommit(1'b0, 32'd0);
        checkOutput("pc_wrap", pc, 32'h0000_0000);

        $display("[TB] ready held low for five cycles");
        doFetch(32'h1234_5678, 5, 0);

        $display("[TB] misaligned redirect is sticky");
        doCommit(1'b1, 32'h0000_0102);
        checkOutput("pc_0x100", pc, 32'h0000_0100);
        doCommit(1'b0, 32'd0);
        doCommit(1'b1, 32'h0000_0200);

        $display("[TB] FETCH abandoned during WAIT");
        applyStimulus(ST_FETCH, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        applyStimulus(ST_FETCH, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        applyStimulus(ST_DECODE, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        applyStimulus(ST_DECODE, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0);
        checkOutput("drop_no_done", {31'd0, fetchDone}, 32'd0);
        checkOutput("drop_instr", instrRaw, mInstr);
        applyStimulus(ST_DECODE, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        checkOutput("drop_no_done_late", {31'd0, fetchDone}, 32'd0);
        doCommit(1'b0, 32'd0);

        $display("[TB] stray response in IDLE");
        applyStimulus(ST_EXEC, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 32'd0);
        checkOutput("stray_instr", instrRaw, mInstr);
        checkOutput("stray_done", {31'd0, fetchDone}, 32'd0);

        $display("[TB] commit during REQ is ignored");
        applyStimulus(ST_FETCH, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        applyStimulus(ST_FETCH, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        checkArch("commit_in_req");
        applyStimulus(ST_FETCH, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        word = $urandom;
        applyStimulus(ST_FETCH, 1'b0, 1'b1, word, 1'b0, 1'b0, 32'd0);
        mInstr = word;
        checkOutput("req_commit_done", {31'd0, fetchDone}, 32'd1);
        checkOutput("req_commit_instr", instrRaw, mInstr);
        applyStimulus(ST_DECODE, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);

        $display("[TB] randomized fetch/commit traffic");
        for (int n = 0; n < 16; n++) begin
            word = $urandom;
            doFetch(word, $urandom_range(0, 3), $urandom_range(0, 2));
            tk  = 1'($urandom_range(0, 1));
            tgt = $urandom;
            if ($urandom_range(0, 3) != 0) tgt = tgt & 32'hFFFF_FFFC;
            doCommit(tk, tgt);
        end

        $display("[TB] reset in WAIT, response afterwards");
        applyStimulus(ST_FETCH, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        applyStimulus(ST_FETCH, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        rst = 1'b1;
        applyStimulus(ST_DECODE, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        rst = 1'b0;
        modelReset();
        applyStimulus(ST_DECODE, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0);
        checkOutput("rst_wait_instr", instrRaw, 32'h0000_0013);
        checkOutput("rst_wait_done", {31'd0, fetchDone}, 32'd0);
        checkArch("rst_wait");
        doCommit(1'b0, 32'd0);
        doFetch(32'h0000_0073, 0, 0);

        $display("[TB] test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the multicycle core. Holds the program counter, fetches one 32-bit instruction word from instruction memory over a request/response handshake while the core is in FETCH (state 0), and presents it as `instr_raw` to the decoder for DECODE (state 1). Takes PC redirects from the write-back stage, and keeps a retired-instruction counter for debug/IO.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value after reset.
- `IMEM_AW`, 15: instruction memory word-address width.
- `clk`  in  1: core clock.
- `rst`  in  1: synchronous, active-high reset.
- `state`  in  3: core state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WRITE=4.
- `imem_req`  out  1: fetch request valid.
- `imem_addr`  out  IMEM_AW: word address, `pc[IMEM_AW+1:2]`.
- `imem_ready`  in  1: memory accepts the request this cycle.
- `imem_rvalid`  in  1: read data valid (one pulse per accepted request).
- `imem_rdata`  in  32: instruction word.
- `commit`  in  1: one-cycle pulse in WRITE; update PC.
- `branch_taken`  in  1: qualifies `commit`; select `branch_target`.
- `branch_target`  in  32: redirect target, already resolved (relative or absolute).
- `pc`  out  32: PC of the instruction in flight (used by auipc/jal).
- `instr_raw`  out  32: latched instruction.
- `fetch_done`  out  1: one-cycle pulse; `instr_raw` is valid, so advance to DECODE.
- `misalign`  out  1: sticky; a redirect target had `[1:0] != 0`.
- `instret`  out  32: retired-instruction count.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: when `state==0`, go to REQ. Otherwise hold.
- REQ:
  - Assert `imem_req` with a stable `imem_addr`.
  - If `imem_ready`, go to WAIT.
  - If `state` leaves 0 before acceptance, deassert `imem_req` and return to IDLE.
- WAIT:
  - On `imem_rvalid`, latch `imem_rdata` into `instr_raw` and go to DONE.
  - If `state` left 0 while in WAIT, set the internal `drop` flag. The response is still consumed but not latched, and the FSM returns to IDLE without `fetch_done`.
- DONE: assert `fetch_done` for exactly one cycle, then go to IDLE.
- `instr_raw` holds its value until the next latched response. It never changes during DECODE through WRITE.
- PC update, on `commit` only:
  - If `branch_taken`: `pc <= {branch_target[31:2], 2'b00}`. If `branch_target[1:0] != 0`, also set `misalign`.
  - Otherwise: `pc <= pc + 4`, with modulo-2^32 wrap (0xFFFF_FFFC becomes 0).
  - `instret <= instret + 1`, wrapping at 2^32.
- `commit` while the FSM is not IDLE is ignored: PC and `instret` are unchanged. This is a controller-protocol violation.
- `imem_rvalid` in IDLE, REQ, or DONE (stray or post-reset response) is ignored.
- `misalign` clears only on `rst`.

## Timing
- Reset values: FSM=IDLE, `pc=RESET_PC`, `instr_raw=32'h0000_0013` (nop), `imem_req=0`, `fetch_done=0`, `misalign=0`, `instret=0`, `drop=0`.
- Reset takes priority over every other event in the same cycle, including a mid-fetch reset. The in-flight request is abandoned, and a later `rvalid` is ignored in IDLE.
- Cycle T, `state` becomes 0 in IDLE: `imem_req=1` at T+1.
- With `imem_ready=1` at T+1 and `imem_rvalid` at T+2:
  - `instr_raw` updates at T+3.
  - `fetch_done=1` at T+3.
  - Minimum fetch latency is 3 cycles from entering FETCH.
- `imem_req` and `imem_addr` stay stable while `imem_ready=0`. There is no timeout.
- `pc` changes only in the cycle after `commit` and is stable for the whole fetch.
- Simultaneous `commit` and `imem_rvalid` cannot occur in legal operation. If they do, the rvalid rule for the current FSM state applies and commit is ignored.

## Structure
- Shared core package `core_pkg`:
  - State constants `ST_FETCH..ST_WRITE` (replacing literal 0..4 across stages).
  - `NOP_INSTR = 32'h0000_0013`.
  - The fetch FSM enum `fetch_st_t`.
- One natural sub-module, `pc_reg`: PC register, next-PC mux, misalign detect, `instret` counter.
- The handshake FSM stays in `fetch_unit`.

## Test plan
- Reset then `state=0`, memory ready and 1-cycle latency returning 32'h00500093 → `imem_addr=0`, `instr_raw=32'h00500093`, `fetch_done` pulses at cycle 3, `pc=0`.
- `commit` with `branch_taken=0` from `pc=0x10` → `pc=0x14`, `instret` increments by 1. From `pc=0xFFFF_FFFC` → `pc=0`.
- `commit`, `branch_taken=1`, `branch_target=0x0000_0102` → `pc=0x100`, `misalign=1`. Stays 1 across further commits until `rst`.
- `imem_ready` held low 5 cycles → `imem_req` and `imem_addr` stable for 5 cycles, then `fetch_done` 2 cycles after acceptance.
- `state` forced to 1 during WAIT, then `rvalid` with 32'hDEADBEEF → `instr_raw` unchanged, no `fetch_done`, FSM returns to IDLE.
- `rst` asserted in WAIT, `rvalid` arrives next cycle → `instr_raw=0x13`, no `fetch_done`, `pc=RESET_PC`. `commit` during REQ → PC unchanged.
